// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor control unit and datapath.
package k_and_s_pkg;

    localparam int unsigned OPCODE_W = 8;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned STATE_W  = 4;

    // Opcode reported by the datapath instruction decoder
    typedef enum logic [OPCODE_W-1:0] {
        I_NOP    = 8'h00,
        I_LOAD   = 8'h01,
        I_STORE  = 8'h02,
        I_MOVE   = 8'h03,
        I_ADD    = 8'h04,
        I_SUB    = 8'h05,
        I_AND    = 8'h06,
        I_OR     = 8'h07,
        I_BRANCH = 8'h08,
        I_BZERO  = 8'h09,
        I_BNZERO = 8'h0A,
        I_BNEG   = 8'h0B,
        I_BNNEG  = 8'h0C,
        I_BOV    = 8'h0D,
        I_BNOV   = 8'h0E,
        I_HALT   = 8'h0F
    } decoded_instruction_type;

    // Control FSM states
    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_LOAD   = 4'd2,
        S_STORE  = 4'd3,
        S_MOVE   = 4'd4,
        S_ALU    = 4'd5,
        S_BRANCH = 4'd6,
        S_NEXT   = 4'd7,
        S_HALT   = 4'd8
    } ctrl_state_t;

    // ALU operation select
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b11;

    // ALU op for an arithmetic/logic opcode; anything else falls back to OR (pass-through)
    function automatic logic [ALU_OP_W-1:0] alu_op_of(input decoded_instruction_type instr);
        logic [ALU_OP_W-1:0] op;
        op = ALU_OR;
        case (instr)
            I_ADD:   op = ALU_ADD;
            I_SUB:   op = ALU_SUB;
            I_AND:   op = ALU_AND;
            default: op = ALU_OR;
        endcase
        return op;
    endfunction

    // Branch condition evaluated against the flag register
    function automatic logic branch_taken(input decoded_instruction_type instr,
                                          input logic zero_op,
                                          input logic neg_op,
                                          input logic unsigned_overflow);
        logic taken;
        taken = 1'b0;
        case (instr)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero_op;
            I_BNZERO: taken = ~zero_op;
            I_BNEG:   taken = neg_op;
            I_BNNEG:  taken = ~neg_op;
            I_BOV:    taken = unsigned_overflow;
            I_BNOV:   taken = ~unsigned_overflow;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Moore control FSM for the K&S processor: fetch, decode, one execute cycle per instruction.
module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [ALU_OP_W-1:0]     operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    ctrl_state_t state;
    ctrl_state_t next_state;

    // No branch condition uses the signed overflow flag
    logic unused_signed_overflow;
    assign unused_signed_overflow = signed_overflow;

    // State register; reset parks the FSM in fetch immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore output decode; outputs follow the state register directly so a
    // reset drops every strobe in the same cycle it is asserted
    always_comb begin
        next_state       = S_FETCH;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = ALU_OR;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        case (state)
            S_FETCH: begin
                addr_sel   = 1'b0;
                ir_enable  = 1'b1;
                next_state = S_DECODE;
            end

            S_DECODE: begin
                case (decoded_instruction)
                    I_LOAD:   next_state = S_LOAD;
                    I_STORE:  next_state = S_STORE;
                    I_MOVE:   next_state = S_MOVE;
                    I_ADD,
                    I_SUB,
                    I_AND,
                    I_OR:     next_state = S_ALU;
                    I_BRANCH,
                    I_BZERO,
                    I_BNZERO,
                    I_BNEG,
                    I_BNNEG,
                    I_BOV,
                    I_BNOV:   next_state = S_BRANCH;
                    I_HALT:   next_state = S_HALT;
                    default:  next_state = S_NEXT;
                endcase
            end

            S_LOAD: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b0;
                write_reg_enable = 1'b1;
                pc_enable        = 1'b1;
                next_state       = S_FETCH;
            end

            S_STORE: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
                pc_enable        = 1'b1;
                next_state       = S_FETCH;
            end

            S_MOVE: begin
                operation        = ALU_OR;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b0;
                pc_enable        = 1'b1;
                next_state       = S_FETCH;
            end

            S_ALU: begin
                // IR is only loaded in fetch, so the opcode is stable here
                operation        = alu_op_of(decoded_instruction);
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
                pc_enable        = 1'b1;
                next_state       = S_FETCH;
            end

            S_BRANCH: begin
                branch     = branch_taken(decoded_instruction, zero_op, neg_op, unsigned_overflow);
                pc_enable  = 1'b1;
                next_state = S_FETCH;
            end

            S_NEXT: begin
                branch     = 1'b0;
                pc_enable  = 1'b1;
                next_state = S_FETCH;
            end

            S_HALT: begin
                halt       = 1'b1;
                next_state = S_HALT;
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port decoded_instruction, input, decoded_instruction_type: current IR opcode from the datapath decoder.
REQ-004 The block SHALL have ports zero_op, neg_op, unsigned_overflow and signed_overflow, inputs, 1 bit each: flag-register contents from the datapath.
REQ-005 The block SHALL have ports branch, pc_enable, ir_enable, addr_sel and c_sel, outputs, 1 bit each: datapath controls.
REQ-006 The block SHALL have port operation, output, 2 bits: ALU op, with 01 add, 10 sub, 11 and, 00 or.
REQ-007 The block SHALL have ports write_reg_enable and flags_reg_enable, outputs, 1 bit each: register-bank and flag-register write strobes.
REQ-008 The block SHALL have port ram_write_enable, output, 1 bit: RAM write strobe.
REQ-009 The block SHALL have port halt, output, 1 bit: processor stopped.

Function
REQ-010 The block SHALL be a Moore FSM; outputs are combinational functions of the state register, and of decoded_instruction/flags in S_BRANCH only.
REQ-011 Outputs not listed for a state SHALL be 0 in that state.
REQ-012 RAM read SHALL be treated as combinational: data is valid in the same cycle ram_addr is driven.
REQ-013 S_FETCH SHALL drive addr_sel=0 and ir_enable=1, then go to S_DECODE.
REQ-014 S_DECODE SHALL assert no enables and SHALL dispatch on decoded_instruction: LOAD->S_LOAD, STORE->S_STORE, MOVE->S_MOVE, ADD/SUB/AND/OR->S_ALU, any branch->S_BRANCH, HALT->S_HALT, NOP or other->S_NEXT.
REQ-015 S_LOAD SHALL drive addr_sel=1, c_sel=0, write_reg_enable=1 and pc_enable=1, then go to S_FETCH.
REQ-016 S_STORE SHALL drive addr_sel=1, ram_write_enable=1 and pc_enable=1, then go to S_FETCH.
REQ-017 S_MOVE SHALL drive operation=00, c_sel=1, write_reg_enable=1, flags_reg_enable=0 and pc_enable=1, then go to S_FETCH.
REQ-018 S_ALU SHALL drive operation per opcode (ADD 01, SUB 10, AND 11, OR 00), c_sel=1, write_reg_enable=1, flags_reg_enable=1 and pc_enable=1, then go to S_FETCH.
REQ-019 S_BRANCH SHALL drive pc_enable=1 and branch=taken, then go to S_FETCH.
REQ-020 Branch taken SHALL be: BRANCH 1; BZERO zero_op; BNZERO !zero_op; BNEG neg_op; BNNEG !neg_op; BOV unsigned_overflow; BNOV !unsigned_overflow.
REQ-021 Flags sampled for branch evaluation SHALL be those of the last ALU instruction; MOVE/LOAD SHALL NOT alter them.
REQ-022 S_NEXT SHALL drive pc_enable=1 and branch=0, then go to S_FETCH.
REQ-023 S_HALT SHALL drive halt=1 with all enables 0 and SHALL remain in S_HALT until reset.
REQ-024 Latency SHALL be 3 cycles per non-HALT instruction (FETCH, DECODE, execute), and PC SHALL increment exactly once per instruction.
REQ-025 The FSM SHALL never assert write_reg_enable and ram_write_enable in the same cycle.
REQ-026 An illegal state encoding SHALL return to S_FETCH on the next edge.

Reset
REQ-027 rst_n low SHALL force the state to S_FETCH immediately, regardless of the current state, including mid-instruction.
REQ-028 While rst_n is low, outputs SHALL be ir_enable=1, addr_sel=0 and all others 0, including halt.
REQ-029 The first rising edge after rst_n deasserts SHALL perform a normal fetch.

Structure
REQ-030 Shared package k_and_s_pkg SHALL hold ctrl_state_t (S_FETCH, S_DECODE, S_LOAD, S_STORE, S_MOVE, S_ALU, S_BRANCH, S_NEXT, S_HALT) and ALU op constants ALU_OR=00, ALU_ADD=01, ALU_SUB=10, ALU_AND=11.
REQ-031 decoded_instruction_type SHALL remain in that package.
REQ-032 The block SHALL be a single module with no sub-module, and SHALL be top-level-paired with data_path.

Verification
REQ-033 Reset, release, IR=ADD: cycles show ir_enable=1, then idle, then operation=01, c_sel=1, write_reg_enable=1, flags_reg_enable=1, pc_enable=1; the next cycle is S_FETCH.
REQ-034 Conditional branches: BZERO with zero_op=1 -> branch=1, pc_enable=1; BZERO with zero_op=0 -> branch=0, pc_enable=1; repeat for BNEG/BNNEG/BOV/BNOV/BNZERO with both flag polarities.
REQ-035 STORE: addr_sel=1, ram_write_enable=1, write_reg_enable=0 for exactly 1 cycle. LOAD: c_sel=0, write_reg_enable=1, addr_sel=1.
REQ-036 HALT: halt=1 held for 100 cycles with pc_enable=0; an rst_n pulse returns to fetch with halt=0.
REQ-037 Reset asserted during S_ALU: write_reg_enable drops the same cycle, and fetch resumes after release.
REQ-038 Opcode 0x00 (NOP): exactly one pc_enable with branch=0 and no write strobes, over 3 cycles.
